// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, default frame constants and the baud divisor helper.
package uart_pkg;

    localparam int unsigned DEFAULT_DATA_SIZE = 8;
    localparam int unsigned DEFAULT_SAMPLE    = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

    // Clocks per oversampling tick.
    function automatic int unsigned baud_dvsr(input int unsigned sys_freq,
                                              input int unsigned baud_rate,
                                              input int unsigned sample);
        return sys_freq / (sample * baud_rate);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Enable-gated sample-tick divider; held at zero while disabled so the tick phase follows enable.
module uart_baud_tick #(
    parameter int unsigned DVSR = 27,
    parameter int unsigned W    = $clog2(DVSR)
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick_c
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (cnt == W'(DVSR - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick_c = en && (cnt == W'(DVSR - 1));

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: synchronizes rx, oversamples it and frames start/data/stop bits
// into bytes with single-cycle valid, framing-error and overrun strobes.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int unsigned SYS_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned SAMPLE    = DEFAULT_SAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 fifo_full,
    output logic [DATA_SIZE-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned BAUD_DVSR = baud_dvsr(SYS_FREQ, BAUD_RATE, SAMPLE);
    localparam int unsigned TICK_W    = $clog2(BAUD_DVSR);
    localparam int unsigned S_W       = $clog2(SAMPLE);
    localparam int unsigned B_W       = $clog2(DATA_SIZE + 1);

    uart_state_e          state;
    logic [S_W-1:0]       s_cnt;
    logic [B_W-1:0]       b_cnt;
    logic [DATA_SIZE-1:0] shreg;
    logic                 rx_meta;
    logic                 rxs;
    logic                 tick;
    logic                 tick_en_c;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign tick_en_c = (state != IDLE);

    uart_baud_tick #(
        .DVSR (BAUD_DVSR),
        .W    (TICK_W)
    ) u_baud_tick (
        .clk    (clk),
        .reset  (reset),
        .en     (tick_en_c),
        .tick_c (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            s_cnt     <= '0;
            b_cnt     <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        s_cnt <= '0;
                        b_cnt <= '0;
                        busy  <= 1'b1;
                    end
                end
                // Mid start bit: a line that is high again was only a glitch.
                START: begin
                    if (tick) begin
                        if (s_cnt == S_W'(SAMPLE / 2 - 1)) begin
                            s_cnt <= '0;
                            if (!rxs) begin
                                state <= DATA;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            s_cnt <= s_cnt + S_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s_cnt == S_W'(SAMPLE - 1)) begin
                            s_cnt <= '0;
                            shreg <= {rxs, shreg[DATA_SIZE-1:1]};
                            if (b_cnt == B_W'(DATA_SIZE - 1)) begin
                                b_cnt <= '0;
                                state <= STOP;
                            end else begin
                                b_cnt <= b_cnt + B_W'(1);
                            end
                        end else begin
                            s_cnt <= s_cnt + S_W'(1);
                        end
                    end
                end
                // Framing error outranks overrun; fifo_full only matters in this cycle.
                STOP: begin
                    if (tick) begin
                        if (s_cnt == S_W'(SAMPLE - 1)) begin
                            s_cnt <= '0;
                            if (!rxs) begin
                                frame_err <= 1'b1;
                                state     <= BREAK;
                            end else begin
                                if (fifo_full) begin
                                    overrun <= 1'b1;
                                end else begin
                                    rx_data  <= shreg;
                                    rx_valid <= 1'b1;
                                end
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            s_cnt <= s_cnt + S_W'(1);
                        end
                    end
                end
                BREAK: begin
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Randomized frame-level bench: expected strobes, bytes and latencies come from the frames driven.
module tb_uart_rx_deserializer;

    localparam int unsigned DVSR    = 27;
    localparam int unsigned BIT     = 16 * DVSR;
    localparam int          LAT_MIN = 4105;
    localparam int          LAT_MAX = 4107;

    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_FERR  = 3'b010;
    localparam logic [2:0] K_OVR   = 3'b001;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         t0;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       fifo_full;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         cyc;
    int         vectors;
    int         miscompares;
    int         n_ferr;
    int         last_lat;
    logic [7:0] model_data;
    exp_t       exp_q[$];
    exp_t       cur;
    logic [2:0] ev;

    uart_rx_deserializer dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .fifo_full (fifo_full),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    task automatic tick_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every strobe must match the oldest outstanding frame; rx_data must hold the last good byte.
    always @(negedge clk) begin
        if (!reset) begin
            ev = {rx_valid, frame_err, overrun};
            if (frame_err) n_ferr++;
            if (ev != 3'b000) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 32'(ev), 32'(0));
                end else begin
                    cur = exp_q.pop_front();
                    last_lat = cyc - cur.t0;
                    check("pulse_kind", 32'(ev), 32'(cur.kind));
                    check("pulse_latency_in_window",
                          32'((last_lat >= LAT_MIN) && (last_lat <= LAT_MAX)), 32'(1));
                    if (cur.kind == K_VALID) model_data = cur.data;
                end
            end
            check("rx_data_hold", 32'(rx_data), 32'(model_data));
        end
    end

    task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                              input int extra_low, input bit ff);
        exp_t e;
        fifo_full = ff;
        e.kind = !stop_ok ? K_FERR : (ff ? K_OVR : K_VALID);
        e.data = d;
        e.t0   = cyc;
        exp_q.push_back(e);
        rx = 1'b0;
        tick_wait(BIT);
        check("busy_in_frame", 32'(busy), 32'(1));
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick_wait(BIT);
        end
        rx = stop_ok;
        tick_wait(BIT);
        if (!stop_ok) begin
            tick_wait(extra_low * BIT);
            rx = 1'b1;
            tick_wait(BIT);
        end
        fifo_full = 1'b0;
        check("frame_resolved", 32'(exp_q.size()), 32'(0));
        check("busy_after_frame", 32'(busy), 32'(0));
    endtask

    task automatic check_quiet(input string name);
        check(name, 32'({rx_valid, frame_err, overrun, busy}), 32'(0));
        check({name, "_data"}, 32'(rx_data), 32'(0));
    endtask

    initial begin
        logic [7:0] d;
        int         mode;
        cyc        = 0;
        vectors    = 0;
        miscompares = 0;
        n_ferr     = 0;
        last_lat   = 0;
        model_data = 8'h00;
        rx         = 1'b1;
        fifo_full  = 1'b0;
        reset      = 1'b1;
        tick_wait(3);
        check_quiet("reset_state");
        reset = 1'b0;
        tick_wait(BIT);

        send_frame(8'hCD, 1'b1, 0, 1'b0);
        check("first_byte", 32'(rx_data), 32'h0000_00CD);
        check("first_latency", 32'((last_lat >= LAT_MIN) && (last_lat <= LAT_MAX)), 32'(1));

        tick_wait(5 * BIT);
        send_frame(8'hCD, 1'b1, 0, 1'b0);
        check("repeat_byte", 32'(rx_data), 32'h0000_00CD);
        send_frame(8'h00, 1'b1, 0, 1'b0);
        check("back_to_back_byte", 32'(rx_data), 32'h0000_0000);
        tick_wait(2 * BIT);

        // Short low pulse must be rejected at mid start bit.
        rx = 1'b0;
        tick_wait(4 * DVSR);
        check("glitch_busy", 32'(busy), 32'(1));
        rx = 1'b1;
        tick_wait(132);
        check("glitch_rejected", 32'({busy, rx_valid, frame_err}), 32'(0));
        tick_wait(BIT);

        send_frame(8'h55, 1'b0, 3, 1'b0);
        check("break_one_ferr", 32'(n_ferr), 32'(1));
        check("break_keeps_data", 32'(rx_data), 32'h0000_0000);
        send_frame(8'hA5, 1'b1, 0, 1'b0);
        check("after_break_byte", 32'(rx_data), 32'h0000_00A5);
        tick_wait(BIT);

        send_frame(8'h3C, 1'b1, 0, 1'b1);
        check("overrun_keeps_data", 32'(rx_data), 32'h0000_00A5);
        send_frame(8'h3C, 1'b1, 0, 1'b0);
        check("after_overrun_byte", 32'(rx_data), 32'h0000_003C);
        tick_wait(BIT);

        // Reset in the middle of data bit 4 discards the frame.
        rx = 1'b0;
        d  = 8'hCD;
        tick_wait(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            tick_wait(BIT);
        end
        rx = d[4];
        tick_wait(200);
        check("busy_before_reset", 32'(busy), 32'(1));
        reset = 1'b1;
        model_data = 8'h00;
        #1;
        check_quiet("async_reset");
        rx = 1'b1;
        tick_wait(3);
        check_quiet("held_reset");
        reset = 1'b0;
        tick_wait(2 * BIT);
        check("reset_no_pulse", 32'(exp_q.size()), 32'(0));
        send_frame(8'hCD, 1'b1, 0, 1'b0);
        check("after_reset_byte", 32'(rx_data), 32'h0000_00CD);

        for (int n = 0; n < 6; n++) begin
            d    = 8'($urandom_range(0, 255));
            mode = int'($urandom_range(0, 3));
            send_frame(d, mode != 0, int'($urandom_range(0, 2)), mode == 1);
            tick_wait(int'($urandom_range(0, 2)) * BIT);
        end
        tick_wait(BIT);
        check("final_queue_empty", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
